neuron_accumulator: RTL



---
 rtl/neuron_accumulator.sv | 123 ++++++++++++
 1 files changed

// File: rtl/neuron_accumulator.sv
// Neuron MAC back end: sums INPUT_COUNT products onto a bias, saturates, optionally rectifies.
// Optional ReLU activation is enabled by defining NEURON_ACCUMULATOR_RELU_EN.
module neuron_accumulator #(
    parameter int unsigned FIXED_POINT_LENGTH   = 16,
    parameter int unsigned FIXED_POINT_POSITION = 10,
    parameter int unsigned INPUT_COUNT          = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    input  logic [FIXED_POINT_LENGTH-1:0] bias_in,
    input  logic [FIXED_POINT_LENGTH-1:0] product_in,
    input  logic                          product_valid_in,
    output logic [FIXED_POINT_LENGTH-1:0] result_out,
    output logic                          result_valid_out,
    output logic                          busy_out
);

    localparam int unsigned CntW = $clog2(INPUT_COUNT + 1);
    localparam int unsigned AccW = FIXED_POINT_LENGTH + CntW + 1;
    localparam int unsigned ExtW = AccW - FIXED_POINT_LENGTH;

    localparam logic signed [AccW-1:0] SatMax =
        {{(ExtW + 1){1'b0}}, {(FIXED_POINT_LENGTH - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(ExtW + 1){1'b1}}, {(FIXED_POINT_LENGTH - 1){1'b0}}};

    // Bias and products share one Q format, so the fraction width only constrains legality.
    if (INPUT_COUNT == 0 || FIXED_POINT_POSITION >= FIXED_POINT_LENGTH) begin : gen_bad_params
        $error("neuron_accumulator: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccumulate,
        StFinalize
    } state_e;

    state_e                          state_q, state_d;
    logic signed [AccW-1:0]          acc_q, acc_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [FIXED_POINT_LENGTH-1:0]   result_q, result_d;
    logic                            result_valid_q, result_valid_d;

    logic signed [AccW-1:0]          bias_ext;
    logic signed [AccW-1:0]          prod_ext;
    logic [CntW-1:0]                 cnt_inc;
    logic [FIXED_POINT_LENGTH-1:0]   sat_val;
    logic [FIXED_POINT_LENGTH-1:0]   act_val;

    assign bias_ext = {{ExtW{bias_in[FIXED_POINT_LENGTH-1]}}, bias_in};
    assign prod_ext = {{ExtW{product_in[FIXED_POINT_LENGTH-1]}}, product_in};
    assign cnt_inc  = cnt_q + CntW'(1);

    always_comb begin
        sat_val = acc_q[FIXED_POINT_LENGTH-1:0];
        if (acc_q > SatMax) begin
            sat_val = {1'b0, {(FIXED_POINT_LENGTH - 1){1'b1}}};
        end else if (acc_q < SatMin) begin
            sat_val = {1'b1, {(FIXED_POINT_LENGTH - 1){1'b0}}};
        end
    end

`ifdef NEURON_ACCUMULATOR_RELU_EN
    assign act_val = sat_val[FIXED_POINT_LENGTH-1] ? '0 : sat_val;
`else
    assign act_val = sat_val;
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    state_d = StAccumulate;
                end
            end
            StAccumulate: begin
                if (product_valid_in) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(INPUT_COUNT)) begin
                        state_d = StFinalize;
                    end
                end
            end
            StFinalize: begin
                result_d       = act_val;
                result_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q        <= StIdle;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result_out       = result_q;
    assign result_valid_out = result_valid_q;
    assign busy_out         = (state_q != StIdle);

endmodule
